pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 192 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures duty cycle of NB_INPUTS asynchronous PWM channels in ticks of CLK_SCALER clocks.
// Optional sticky per-channel overrun flags are built when PWM_CAPTURE_OVERRUN_EN is defined.
module pwm_capture #(
  parameter int CLK_SCALER = 100000,
  parameter int NB_INPUTS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [NB_INPUTS-1:0]         pwm_in,
  output logic                         duty_valid,
  input  logic                         duty_ready,
  output logic [7:0]                   duty_cycle,
  output logic [$clog2(NB_INPUTS)-1:0] duty_channel,
  output logic [NB_INPUTS-1:0]         overrun,
  input  logic                         clr_overrun
);

  localparam int CW = $clog2(NB_INPUTS);
  localparam int PW = (CLK_SCALER > 1) ? $clog2(CLK_SCALER) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_SCALER - 1);
  localparam logic [8:0] CNT_SAT = 9'd256;

  logic [NB_INPUTS-1:0] sync1, sync2, sync_prev;
  logic [NB_INPUTS-1:0] rise;

  logic [PW-1:0] presc;
  logic          tick;

  logic [8:0] high_cnt   [NB_INPUTS];
  logic [8:0] period_cnt [NB_INPUTS];
  logic [7:0] slot       [NB_INPUTS];
  logic [NB_INPUTS-1:0] armed, pending;

  logic [NB_INPUTS-1:0] restart, result_vld, ovr_evt;
  logic [7:0]           result_val [NB_INPUTS];

  logic                 load_en, grant_any;
  logic [CW-1:0]        grant_idx, last_grant;
  logic [NB_INPUTS-1:0] grant_oh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= pwm_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

  assign tick = run && (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc <= '0;
    else if (!run || tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  // A rising edge always wins over a timeout seen in the same cycle.
  always_comb begin
    restart    = '0;
    result_vld = '0;
    ovr_evt    = '0;
    for (int i = 0; i < NB_INPUTS; i++) begin
      result_val[i] = '0;
      if (run) begin
        if (rise[i]) begin
          restart[i] = 1'b1;
          if (armed[i]) begin
            result_vld[i] = 1'b1;
            result_val[i] = high_cnt[i][8] ? 8'hFF : high_cnt[i][7:0];
          end
        end else if (period_cnt[i] == CNT_SAT) begin
          restart[i]    = 1'b1;
          result_vld[i] = 1'b1;
          result_val[i] = sync2[i] ? 8'hFF : 8'h00;
        end
      end
      ovr_evt[i] = result_vld[i] & pending[i] & ~grant_oh[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= '0;
      pending <= '0;
      for (int i = 0; i < NB_INPUTS; i++) begin
        high_cnt[i]   <= '0;
        period_cnt[i] <= '0;
        slot[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < NB_INPUTS; i++) begin
        if (!run) begin
          high_cnt[i]   <= '0;
          period_cnt[i] <= '0;
          armed[i]      <= 1'b0;
        end else if (restart[i]) begin
          high_cnt[i]   <= '0;
          period_cnt[i] <= '0;
          armed[i]      <= 1'b1;
        end else if (tick) begin
          if (period_cnt[i] != CNT_SAT)
            period_cnt[i] <= period_cnt[i] + 9'd1;
          if (sync2[i] && (high_cnt[i] != CNT_SAT))
            high_cnt[i] <= high_cnt[i] + 9'd1;
        end

        if (result_vld[i])
          slot[i] <= result_val[i];

        if (!run)
          pending[i] <= 1'b0;
        else if (result_vld[i])
          pending[i] <= 1'b1;
        else if (grant_oh[i])
          pending[i] <= 1'b0;
      end
    end
  end

  assign load_en = ~duty_valid | duty_ready;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = last_grant;
    grant_oh  = '0;
    if (load_en) begin
      for (int k = 1; k <= NB_INPUTS; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NB_INPUTS)
          idx = idx - NB_INPUTS;
        if (!grant_any && pending[idx]) begin
          grant_any = 1'b1;
          grant_idx = CW'(idx);
        end
      end
      if (grant_any)
        grant_oh[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_valid   <= 1'b0;
      duty_cycle   <= '0;
      duty_channel <= '0;
      last_grant   <= CW'(NB_INPUTS - 1);
    end else if (load_en) begin
      if (grant_any) begin
        duty_valid   <= 1'b1;
        duty_cycle   <= slot[grant_idx];
        duty_channel <= grant_idx;
        last_grant   <= grant_idx;
      end else begin
        duty_valid   <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_OVERRUN_EN
  logic [NB_INPUTS-1:0] overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun_q <= '0;
    else if (clr_overrun)
      overrun_q <= '0;
    else
      overrun_q <= overrun_q | ovr_evt;
  end

  assign overrun = overrun_q;
`else
  logic unused_overrun;

  assign overrun        = '0;
  assign unused_overrun = clr_overrun | (|ovr_evt);
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture with CLK_SCALER=4, NB_INPUTS=8.
module tb_pwm_capture;

  localparam int NB = 8;
  localparam int CS = 4;
`ifdef PWM_CAPTURE_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [NB-1:0] pwm_in = '0;
  logic          duty_valid;
  logic          duty_ready = 1'b0;
  logic [7:0]    duty_cycle;
  logic [2:0]    duty_channel;
  logic [NB-1:0] overrun;
  logic          clr_overrun = 1'b0;

  int total = 0;
  int bad   = 0;

  pwm_capture #(.CLK_SCALER(CS), .NB_INPUTS(NB)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .pwm_in       (pwm_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_cycle   (duty_cycle),
    .duty_channel (duty_channel),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean start: reset pulse (pointer back to NB-1), then enable.
  task automatic restart();
    run    = 1'b0;
    pwm_in = '0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(4);
    run = 1'b1;
  endtask

  task automatic wait_ch(input int ch, input int budget, input string tag, output logic [7:0] val);
    bit found;
    found = 1'b0;
    val   = 8'h00;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (duty_valid && (int'(duty_channel) == ch)) begin
        found = 1'b1;
        val   = duty_cycle;
      end
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_timeout: observed=no result expected=result on ch%0d", tag, ch);
    end
  endtask

  task automatic wait_any(input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (duty_valid) found = 1'b1;
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_timeout: observed=no result expected=duty_valid", tag);
    end
  endtask

  initial begin
    logic [7:0] v;
    int seen;

    // reset state
    cycles(3);
    @(negedge clk);
    check("rst_valid",   32'(duty_valid),   0);
    check("rst_cycle",   32'(duty_cycle),   0);
    check("rst_channel", 32'(duty_channel), 0);
    check("rst_overrun", 32'(overrun),      0);
    rst = 1'b1;

    // ch0: 257 cycles high (64 ticks), period 1020 cycles
    restart();
    duty_ready = 1'b1;
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          pwm_in[0] = 1'b1;
          cycles(257);
          pwm_in[0] = 1'b0;
          cycles(763);
        end
      end
      begin
        wait_ch(0, 1300, "ch0_p2", v);
        check("ch0_p2_duty", 32'(v), 64);
        wait_ch(0, 1200, "ch0_p3", v);
        check("ch0_p3_duty", 32'(v), 64);
      end
    join

    // ch3 timeout, low then high
    restart();
    wait_ch(3, 1200, "ch3_low", v);
    check("ch3_low_duty", 32'(v), 0);
    run    = 1'b0;
    pwm_in = 8'b0000_1000;
    cycles(6);
    run = 1'b1;
    wait_ch(3, 1200, "ch3_high", v);
    check("ch3_high_duty", 32'(v), 255);

    // round robin: ch1+ch2 together, then ch3+ch1 with pointer at ch2
    restart();
    pwm_in = 8'b0000_1110;
    cycles(41);
    pwm_in = 8'b0000_1000;
    cycles(40);
    pwm_in = 8'b0000_0000;
    cycles(20);
    pwm_in = 8'b0000_0110;
    fork
      begin
        cycles(41);
        pwm_in = 8'b0000_0000;
        cycles(20);
        pwm_in = 8'b0000_1010;
        cycles(41);
        pwm_in = 8'b0000_0000;
      end
      begin
        wait_any(30, "rr_b");
        check("rr_b_first_ch",   32'(duty_channel), 1);
        check("rr_b_first_duty", 32'(duty_cycle),   10);
        @(negedge clk);
        check("rr_b_second_vld",  32'(duty_valid),   1);
        check("rr_b_second_ch",   32'(duty_channel), 2);
        check("rr_b_second_duty", 32'(duty_cycle),   10);
        wait_any(200, "rr_c");
        check("rr_c_first_ch",   32'(duty_channel), 3);
        check("rr_c_first_duty", 32'(duty_cycle),   20);
        @(negedge clk);
        check("rr_c_second_vld",  32'(duty_valid),   1);
        check("rr_c_second_ch",   32'(duty_channel), 1);
        check("rr_c_second_duty", 32'(duty_cycle),   10);
      end
    join

    // backpressure on ch5, three results: 10 held, 20 overwritten by 5
    restart();
    duty_ready = 1'b0;
    pwm_in[5] = 1'b1;
    cycles(41);
    pwm_in[5] = 1'b0;
    cycles(20);
    pwm_in[5] = 1'b1;
    cycles(81);
    pwm_in[5] = 1'b0;
    cycles(20);
    @(negedge clk);
    check("bp_first_vld",  32'(duty_valid),   1);
    check("bp_first_ch",   32'(duty_channel), 5);
    check("bp_first_duty", 32'(duty_cycle),   10);
    cycles(1);
    pwm_in[5] = 1'b1;
    cycles(21);
    pwm_in[5] = 1'b0;
    cycles(20);
    @(negedge clk);
    check("bp_hold1_duty", 32'(duty_cycle), 10);
    check("bp_no_ovr_yet", 32'(overrun),    0);
    cycles(1);
    pwm_in[5] = 1'b1;
    cycles(21);
    pwm_in[5] = 1'b0;
    cycles(5);
    @(negedge clk);
    check("bp_hold2_duty", 32'(duty_cycle),   10);
    check("bp_hold2_ch",   32'(duty_channel), 5);
    check("bp_ovr5",       32'(overrun),      32'({EXP_OVR, 5'b0}));
    cycles(1);
    duty_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_old", 32'(duty_cycle), 10);
    @(negedge clk);
    check("bp_next_vld",  32'(duty_valid), 1);
    check("bp_next_duty", 32'(duty_cycle), 5);
    @(negedge clk);
    check("bp_drained", 32'(duty_valid), 0);
    cycles(1);
    clr_overrun = 1'b1;
    cycles(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    check("bp_ovr_cleared", 32'(overrun), 0);

    // reset mid-transfer
    restart();
    duty_ready = 1'b0;
    pwm_in[5] = 1'b1;
    cycles(41);
    pwm_in[5] = 1'b0;
    cycles(20);
    pwm_in[5] = 1'b1;
    cycles(10);
    @(negedge clk);
    check("mid_vld_before", 32'(duty_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("mid_vld_async", 32'(duty_valid),   0);
    check("mid_cycle_rst", 32'(duty_cycle),   0);
    check("mid_ch_rst",    32'(duty_channel), 0);
    cycles(2);
    @(negedge clk);
    rst = 1'b1;
    duty_ready = 1'b1;
    cycles(8);
    pwm_in[4] = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (duty_valid) seen++;
    end
    check("post_rst_no_result", 32'(seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
